hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core. Watches register addresses and control bits in the decode, execute, memory and writeback stages. Drives the stall and flush enables of the F/D, D/E, E/M and M/W pipeline registers, and the execute-stage operand forwarding selects. Also sequences multi-cycle load-use bubbles and data-memory wait states, and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- LOAD_USE_BUBBLES, 1, bubble cycles inserted per load-use hazard (1..7)
- CNT_WIDTH, 32, width of performance counters

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- rs1D_i, rs2D_i  in  5 each  source registers in decode
- rs1E_i, rs2E_i  in  5 each  source registers in execute
- rdE_i, rdM_i, rdW_i  in  5 each  destination registers in E/M/W
- result_srcE_i  in  1  1 = instruction in E is a load
- reg_writeM_i, reg_writeW_i  in  1 each  register write enables in M/W
- pc_srcE_i  in  1  taken branch/jump resolved in E
- mem_reqM_i  in  1  M-stage instruction accesses data memory
- dmem_ready_i  in  1  data memory completes access this cycle
- stallF_o, stallD_o, stallE_o, stallM_o  out  1 each  hold PC / pipeline register
- flushD_o, flushE_o, flushW_o  out  1 each  load bubble into register
- forward_aE_o, forward_bE_o  out  2 each  operand select: 00 regfile, 01 W result, 10 M ALU result
- stall_cycles_o  out  CNT_WIDTH  cycles with stallF_o high
- flush_events_o  out  CNT_WIDTH  cycles with pc_srcE_i redirect flush

## Operation
- Forwarding, per operand (shown for A; B uses rs2E_i):
  - select 10 if reg_writeM_i, rdM_i != 0 and rdM_i == rs1E_i;
  - else 01 if reg_writeW_i, rdW_i != 0 and rdW_i == rs1E_i;
  - else 00.
  - M has priority over W.
- Load-use hazard: result_srcE_i, rdE_i != 0, and rdE_i == rs1D_i or rdE_i == rs2D_i.
- FSM states: RUN, BUBBLE, MEM_WAIT. Hazards are evaluated in priority order below.
- Priority 1 — memory wait, any state: when mem_reqM_i & !dmem_ready_i:
  - assert stallF/D/E/M and flushW;
  - all other flushes low;
  - state goes to MEM_WAIT; the BUBBLE counter, if nonzero, is frozen.
- MEM_WAIT exit: when dmem_ready_i is high, outputs follow the RUN/BUBBLE rules in the same cycle. Next state is BUBBLE if the counter is nonzero, else RUN.
- Priority 2 — redirect: pc_srcE_i in RUN or BUBBLE:
  - assert flushD and flushE, no stalls;
  - clear the bubble counter, go to RUN;
  - any load-use hazard is ignored (the D instruction is discarded).
- Priority 3 — load-use in RUN:
  - assert stallF, stallD, flushE;
  - if LOAD_USE_BUBBLES > 1, load the counter with LOAD_USE_BUBBLES-1 and go to BUBBLE.
- BUBBLE:
  - assert stallF, stallD, flushE;
  - decrement the counter each cycle;
  - return to RUN when it reaches 0 (the transition happens at the end of the cycle in which the count was 1).
- Counters saturate at all-ones and never wrap.
  - stall_cycles_o increments each cycle stallF_o is high.
  - flush_events_o increments each cycle a redirect flush is asserted.

## Timing
- Forward selects and stall/flush outputs are Mealy, combinational from inputs and state: zero latency, same-cycle.
- State, bubble counter and perf counters update on clk_i rising edge.
- While rst_ni is low:
  - state RUN, bubble counter 0, both perf counters 0;
  - flushD_o, flushE_o, flushW_o = 1;
  - all stalls = 0, forward selects = 00.
- Reset deassertion mid-stall: first cycle after reset is RUN with no residual bubbles.
- Load-use with LOAD_USE_BUBBLES=N: stallF high for exactly N consecutive cycles, absent memory wait or redirect.
- Simultaneous MEM_WAIT and redirect: the stall wins. The redirect is retained in E (stallE) and takes effect the cycle dmem_ready_i rises.
- Combinational output paths: no path from any stall/flush output back to an input, so no combinational loop.

## Structure
- Shared package pipeline_pkg holds:
  - fwd_sel_e enum: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - hz_state_e enum: RUN, BUBBLE, MEM_WAIT;
  - REG_ADDR_WIDTH=5.
- One sub-module, fwd_sel, is instanced twice (operand A and B): combinational priority compare producing fwd_sel_e.
- The FSM, bubble counter and perf counters live in hazard_ctrl.

## Test plan
- Forwarding: rs1E=5, rdM=5, reg_writeM=1, rdW=5, reg_writeW=1 -> forward_aE=10. With reg_writeM=0 -> 01. With rdM=rdW=0 -> 00.
- Load-use, N=1: result_srcE=1, rdE=3, rs2D=3 -> one cycle of stallF=stallD=flushE=1, then all low; stall_cycles_o=1.
- Load-use, N=3, with mem_reqM=1 and dmem_ready=0 arriving in bubble cycle 2:
  - 2 wait cycles with stallF/D/E/M=1 and flushW=1;
  - bubbles then resume;
  - stallF high 5 cycles total.
- Redirect during BUBBLE (N=3, pc_srcE=1 in bubble 1) -> flushD=flushE=1, stalls 0, state RUN next cycle; flush_events_o increments by 1.
- Reset asserted mid-MEM_WAIT -> outputs immediately show flushD/E/W=1, stalls 0. After release: RUN, counters 0.
- Saturation, CNT_WIDTH=4: 20 load-use stalls -> stall_cycles_o holds 15.

Source files
------------

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: types and constants shared by the pipeline control blocks.
//   fwd_sel_e  - execute-stage operand source (regfile / W result / M ALU result)
//   hz_state_e - hazard controller sequencing state
package pipeline_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN,
    BUBBLE,
    MEM_WAIT
  } hz_state_e;

endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: forwarding source select for one execute-stage operand.
// Ports:
//   rs          - source register of the operand in E
//   rd_m, rd_w  - destination registers in M and W
//   reg_write_m - M-stage instruction writes rd_m
//   reg_write_w - W-stage instruction writes rd_w
//   sel         - FWD_M / FWD_W / FWD_RF; M wins because it holds the newer value
module fwd_sel
  import pipeline_pkg::*;
(
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic                      reg_write_m,
  input  logic                      reg_write_w,
  output fwd_sel_e                  sel
);

  // NOTE: sel gets a default before the if-chain so no path leaves it
  // unassigned; otherwise a latch would be inferred.
  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard controller for the five-stage pipeline.
// Ports:
//   clk_i, rst_ni              - clock, asynchronous active-low reset
//   rs1D_i, rs2D_i             - decode source registers (load-use detection)
//   rs1E_i, rs2E_i             - execute source registers (forwarding)
//   rdE_i, rdM_i, rdW_i        - destination registers in E/M/W
//   result_srcE_i              - E instruction is a load
//   reg_writeM_i, reg_writeW_i - M/W write enables
//   pc_srcE_i                  - taken branch/jump resolved in E
//   mem_reqM_i, dmem_ready_i   - M data-memory access and its completion
//   stall*_o, flush*_o         - pipeline register hold / bubble enables
//   forward_aE_o, forward_bE_o - operand forwarding selects
//   stall_cycles_o             - saturating count of cycles with stallF_o high
//   flush_events_o             - saturating count of redirect-flush cycles
// All stall/flush/forward outputs are combinational from inputs and state.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1E_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2E_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdE_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdM_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdW_i,
  input  logic                      result_srcE_i,
  input  logic                      reg_writeM_i,
  input  logic                      reg_writeW_i,
  input  logic                      pc_srcE_i,
  input  logic                      mem_reqM_i,
  input  logic                      dmem_ready_i,
  output logic                      stallF_o,
  output logic                      stallD_o,
  output logic                      stallE_o,
  output logic                      stallM_o,
  output logic                      flushD_o,
  output logic                      flushE_o,
  output logic                      flushW_o,
  output logic [1:0]                forward_aE_o,
  output logic [1:0]                forward_bE_o,
  output logic [CNT_WIDTH-1:0]      stall_cycles_o,
  output logic [CNT_WIDTH-1:0]      flush_events_o
);

  localparam logic [2:0] BUBBLE_RELOAD = 3'(LOAD_USE_BUBBLES - 1);

  hz_state_e            state_q, state_d;
  logic [2:0]           bub_q, bub_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

  fwd_sel_e sel_a, sel_b;
  logic     mem_wait, load_use, in_bubble, redirect_flush;

  fwd_sel u_fwd_a (
    .rs          (rs1E_i),
    .rd_m        (rdM_i),
    .rd_w        (rdW_i),
    .reg_write_m (reg_writeM_i),
    .reg_write_w (reg_writeW_i),
    .sel         (sel_a)
  );

  fwd_sel u_fwd_b (
    .rs          (rs2E_i),
    .rd_m        (rdM_i),
    .rd_w        (rdW_i),
    .reg_write_m (reg_writeM_i),
    .reg_write_w (reg_writeW_i),
    .sel         (sel_b)
  );

  assign forward_aE_o = rst_ni ? sel_a : FWD_RF;
  assign forward_bE_o = rst_ni ? sel_b : FWD_RF;

  assign mem_wait = mem_reqM_i & ~dmem_ready_i;
  assign load_use = result_srcE_i && (rdE_i != '0) &&
                    ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));

  // Leaving MEM_WAIT with bubbles still owed behaves as a BUBBLE cycle.
  assign in_bubble = (state_q == BUBBLE) || ((state_q == MEM_WAIT) && (bub_q != '0));

  always_comb begin
    stallF_o       = 1'b0;
    stallD_o       = 1'b0;
    stallE_o       = 1'b0;
    stallM_o       = 1'b0;
    flushD_o       = 1'b0;
    flushE_o       = 1'b0;
    flushW_o       = 1'b0;
    redirect_flush = 1'b0;
    state_d        = RUN;
    bub_d          = bub_q;

    if (!rst_ni) begin
      // Bubbles into every register while reset is held.
      flushD_o = 1'b1;
      flushE_o = 1'b1;
      flushW_o = 1'b1;
    end else if (mem_wait) begin
      // Freeze F..M (E keeps any pending redirect); W gets a bubble.
      stallF_o = 1'b1;
      stallD_o = 1'b1;
      stallE_o = 1'b1;
      stallM_o = 1'b1;
      flushW_o = 1'b1;
      state_d  = MEM_WAIT;
    end else if (pc_srcE_i) begin
      flushD_o       = 1'b1;
      flushE_o       = 1'b1;
      redirect_flush = 1'b1;
      bub_d          = '0;
    end else if (in_bubble) begin
      stallF_o = 1'b1;
      stallD_o = 1'b1;
      flushE_o = 1'b1;
      bub_d    = bub_q - 3'd1;
      state_d  = (bub_q == 3'd1) ? RUN : BUBBLE;
    end else if (load_use) begin
      stallF_o = 1'b1;
      stallD_o = 1'b1;
      flushE_o = 1'b1;
      if (LOAD_USE_BUBBLES > 1) begin
        bub_d   = BUBBLE_RELOAD;
        state_d = BUBBLE;
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      bub_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      if (stallF_o && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
      if (redirect_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_events_o = flush_cnt_q;

endmodule
